// File: rtl/feeder_pkg.sv
// feeder_pkg: definitions shared by the west-edge feeder and its skew lines.
//   state_t      : feeder FSM states (IDLE / STREAM / FLUSH / DONE)
//   INST_*       : per-row tile instruction encodings
//   MODE_*       : array-wide dataflow mode encodings
//   op_inst()    : maps the command op bit to the instruction driven on data beats
package feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    localparam logic MODE_WS = 1'b0;
    localparam logic MODE_OS = 1'b1;

    // op=0 loads kernel weights, op=1 executes; 2'b11 is never produced.
    function automatic logic [1:0] op_inst(input logic op);
        return op ? INST_EXEC : INST_KLOAD;
    endfunction

endpackage

// File: rtl/skew_line.sv
// skew_line: fixed-depth registered delay line with asynchronous clear.
//   clk   : clock
//   reset : asynchronous active-low clear of every stage
//   d     : beat entering stage 0 at each rising edge
//   q     : output of the last stage (d delayed by DEPTH edges)
module skew_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/west_feeder.sv
// west_feeder: drives the west edge of the systolic MAC array.
//   clk, reset      : clock, asynchronous active-low reset
//   cmd_*           : command (op, mode, length) offered to the feeder
//   in_valid/ready  : host vector handshake, in_data holds one element per row
//   out_w, inst_w   : per-row data and instruction into the west tile column
//   mode            : dataflow mode latched at command accept
//   done            : one-cycle pulse once the last beat has left the last row
//   err_bubble      : sticky flag, a bubble was injected during an OS execute
//   state_dbg       : current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready is decoded from the FSM state alone and never looks at
// valid; valid may be raised or dropped by the source at any time.
module west_feeder
    import feeder_pkg::*;
#(
    parameter int bw     = 4,
    parameter int row    = 8,
    parameter int len_bw = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic                cmd_mode,
    input  logic [len_bw-1:0]   cmd_len,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [row*bw-1:0]   in_data,
    output logic [row*bw-1:0]   out_w,
    output logic [2*row-1:0]    inst_w,
    output logic                mode,
    output logic                done,
    output logic                err_bubble,
    output logic [1:0]          state_dbg
);

    localparam int FW = $clog2(row) + 1;

    state_t            state;
    logic              op_q;
    logic              mode_q;
    logic [len_bw-1:0] remaining;
    logic [FW-1:0]     flush_cnt;
    logic              vec_accept;

    assign cmd_ready  = (state == ST_IDLE);
    assign in_ready   = (state == ST_STREAM);
    assign done       = (state == ST_DONE);
    assign mode       = mode_q;
    assign state_dbg  = state;
    assign vec_accept = (state == ST_STREAM) && in_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            op_q       <= 1'b0;
            mode_q     <= MODE_WS;
            remaining  <= '0;
            flush_cnt  <= '0;
            err_bubble <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        mode_q    <= cmd_mode;
                        remaining <= cmd_len;
                        state     <= (cmd_len == '0) ? ST_DONE : ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (in_valid) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == len_bw'(1)) begin
                            // The final beat needs row-1 more edges to reach
                            // the last row; done follows one edge later.
                            flush_cnt <= FW'(row - 1);
                            state     <= ST_FLUSH;
                        end
                    end else if (op_q && (mode_q == MODE_OS)) begin
                        err_bubble <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == '0) begin
                        state <= ST_DONE;
                    end else begin
                        flush_cnt <= flush_cnt - 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Row r gets r+1 register stages, producing the diagonal wavefront.
    // Any cycle without a vector accept injects an all-zero bubble.
    for (genvar r = 0; r < row; r++) begin : g_row
        logic [bw+1:0] inj;
        logic [bw+1:0] tap;

        assign inj = vec_accept ? {op_inst(op_q), in_data[r*bw +: bw]} : '0;

        skew_line #(
            .DEPTH (r + 1),
            .WIDTH (bw + 2)
        ) u_skew (
            .clk   (clk),
            .reset (reset),
            .d     (inj),
            .q     (tap)
        );

        assign out_w[r*bw +: bw] = tap[bw-1:0];
        assign inst_w[2*r +: 2]  = tap[bw+1:bw];
    end

endmodule
